// File: rtl/usb_pulpino_gpio_link.sv
// Host-side bridge: 32-bit words <-> bytes on the PULPino GPIO toggle-handshake bus.
// TX drives data[7:0], byte-write[9], word-write[11]; RX acks with byte-read[8], word-read[10].
module usb_pulpino_gpio_link #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_word,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_word,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [31:0] gpio_to_pulpino,
    input  logic [31:0] gpio_from_pulpino,
    output logic        timeout_err,
    input  logic        err_clr,
    output logic        busy
);
    localparam int unsigned TW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int unsigned TLIM = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

    typedef enum logic [1:0] {TX_IDLE, TX_BYTE, TX_BACK, TX_WACK} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_HOLD} rx_state_t;

    // hs_ev bit map: [0] byte-read, [1] byte-write, [2] word-read, [3] word-write
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0] hs_prev, hs_ev;
    logic       unused_hi;

    assign unused_hi = ^gpio_from_pulpino[31:12];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            hs_prev <= '0;
        end else begin
            sync_q[0] <= gpio_from_pulpino[11:8];
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hs_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign hs_ev = sync_q[SYNC_STAGES-1] ^ hs_prev;

    tx_state_t   tx_st, tx_nxt;
    logic [31:0] tx_buf;
    logic [1:0]  tx_cnt;
    logic [TW-1:0] tmr;
    logic [7:0]  data_q;
    logic        tgl_bw, tgl_ww, tgl_br, tgl_wr;
    logic        tx_acc, tx_send, tx_dec, tx_last, tx_to, timed_out;

    always_comb begin
        tx_nxt    = tx_st;
        tx_acc    = 1'b0;
        tx_send   = 1'b0;
        tx_dec    = 1'b0;
        tx_last   = 1'b0;
        tx_to     = 1'b0;
        timed_out = (ACK_TIMEOUT != 0) && (tmr == TW'(TLIM));
        case (tx_st)
            TX_IDLE: if (tx_valid) begin
                tx_acc = 1'b1;
                tx_nxt = TX_BYTE;
            end
            TX_BYTE: begin
                tx_send = 1'b1;
                tx_nxt  = TX_BACK;
            end
            TX_BACK: begin
                if (hs_ev[0]) begin
                    if (tx_cnt != 2'd0) begin
                        tx_dec = 1'b1;
                        tx_nxt = TX_BYTE;
                    end else begin
                        tx_last = 1'b1;
                        tx_nxt  = TX_WACK;
                    end
                end else if (timed_out) begin
                    tx_to  = 1'b1;
                    tx_nxt = TX_IDLE;
                end
            end
            TX_WACK: begin
                if (hs_ev[2]) begin
                    tx_nxt = TX_IDLE;
                end else if (timed_out) begin
                    tx_to  = 1'b1;
                    tx_nxt = TX_IDLE;
                end
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st       <= TX_IDLE;
            tx_buf      <= '0;
            tx_cnt      <= '0;
            tmr         <= '0;
            data_q      <= '0;
            tgl_bw      <= 1'b0;
            tgl_ww      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_st <= tx_nxt;
            if (tx_acc) begin
                tx_buf <= tx_word;
                tx_cnt <= 2'd3;
            end
            if (tx_send) begin
                data_q <= tx_buf[{tx_cnt, 3'b000} +: 8];
                tgl_bw <= ~tgl_bw;
            end
            if (tx_dec)  tx_cnt <= tx_cnt - 2'd1;
            if (tx_last) tgl_ww <= ~tgl_ww;
            // timer restarts whenever the state changes, including BACK->BYTE->BACK
            tmr <= (tx_nxt != tx_st) ? '0 : tmr + TW'(1);
            if (tx_to)        timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    rx_state_t   rx_st, rx_nxt;
    logic [31:0] rx_shift, shift_in;
    logic        rx_pend, rx_take, rx_load, rx_done;

    assign shift_in = {rx_shift[23:0], gpio_from_pulpino[7:0]};

    always_comb begin
        rx_nxt  = rx_st;
        rx_take = 1'b0;
        rx_load = 1'b0;
        rx_done = 1'b0;
        case (rx_st)
            RX_IDLE, RX_COLLECT: begin
                rx_take = hs_ev[1] | rx_pend;
                if (hs_ev[3]) begin
                    rx_load = 1'b1;
                    rx_nxt  = RX_HOLD;
                end else if (rx_take) begin
                    rx_nxt = RX_COLLECT;
                end
            end
            RX_HOLD: if (rx_ready) begin
                rx_done = 1'b1;
                rx_nxt  = RX_IDLE;
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st    <= RX_IDLE;
            rx_shift <= '0;
            rx_word  <= '0;
            rx_valid <= 1'b0;
            rx_pend  <= 1'b0;
            tgl_br   <= 1'b0;
            tgl_wr   <= 1'b0;
        end else begin
            rx_st <= rx_nxt;
            if (rx_take) begin
                rx_shift <= shift_in;
                tgl_br   <= ~tgl_br;
            end
            // a byte arriving with the word-write belongs to that word
            if (rx_load) begin
                rx_word  <= rx_take ? shift_in : rx_shift;
                rx_valid <= 1'b1;
            end
            if (rx_done) begin
                rx_valid <= 1'b0;
                rx_shift <= '0;
                tgl_wr   <= ~tgl_wr;
            end
            if (rx_st == RX_HOLD) begin
                if (hs_ev[1]) rx_pend <= 1'b1;
            end else if (rx_take) begin
                rx_pend <= 1'b0;
            end
        end
    end

    assign tx_ready        = (tx_st == TX_IDLE) & ~rst;
    assign busy            = (tx_st != TX_IDLE) | (rx_st != RX_IDLE);
    assign gpio_to_pulpino = {20'd0, tgl_ww, tgl_wr, tgl_bw, tgl_br, data_q};

endmodule

// File: tb/tb_usb_pulpino_gpio_link.sv
// Directed bench for usb_pulpino_gpio_link with a toggle-acking PULPino model.
module tb_usb_pulpino_gpio_link;
    logic        clk = 0;
    logic        rst;
    logic [31:0] tx_word;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_word;
    logic        rx_valid, rx_ready;
    logic [31:0] gpio_to_pulpino, gpio_from_pulpino;
    logic        timeout_err, err_clr, busy;

    logic [7:0] p_data;
    logic       p_br, p_bw, p_wr, p_ww;
    bit         ack_en;
    logic [7:0] tx_bytes[$];
    int         ww_flips, ww_at, br_flips, wr_flips;
    int         checks, errors;

    assign gpio_from_pulpino = {20'd0, p_ww, p_wr, p_bw, p_br, p_data};

    always #5 clk = ~clk;

    usb_pulpino_gpio_link #(.SYNC_STAGES(2), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .gpio_to_pulpino(gpio_to_pulpino), .gpio_from_pulpino(gpio_from_pulpino),
        .timeout_err(timeout_err), .err_clr(err_clr), .busy(busy)
    );

    // PULPino model: acks byte-write / word-write toggles 5 cycles later, logs traffic
    initial begin
        logic l8, l9, l10, l11;
        int cb, cw;
        l8 = 0; l9 = 0; l10 = 0; l11 = 0; cb = -1; cw = -1;
        p_br = 0; p_wr = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                l8 = 0; l9 = 0; l10 = 0; l11 = 0; cb = -1; cw = -1; p_br = 0; p_wr = 0;
            end else begin
                if (cb == 0) p_br = ~p_br;
                if (cw == 0) p_wr = ~p_wr;
                if (cb >= 0) cb--;
                if (cw >= 0) cw--;
                if (gpio_to_pulpino[9] !== l9) begin
                    l9 = gpio_to_pulpino[9];
                    tx_bytes.push_back(gpio_to_pulpino[7:0]);
                    if (ack_en) cb = 4;
                end
                if (gpio_to_pulpino[11] !== l11) begin
                    l11 = gpio_to_pulpino[11];
                    ww_flips++;
                    ww_at = tx_bytes.size();
                    if (ack_en) cw = 4;
                end
                if (gpio_to_pulpino[8] !== l8) begin l8 = gpio_to_pulpino[8]; br_flips++; end
                if (gpio_to_pulpino[10] !== l10) begin l10 = gpio_to_pulpino[10]; wr_flips++; end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; p_data = 0; p_bw = 0; p_ww = 0; tx_valid = 0; rx_ready = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic tx_send(input logic [31:0] w);
        @(negedge clk); tx_word = w; tx_valid = 1;
        @(posedge clk); #1; tx_valid = 0;
    endtask

    task automatic tx_wait_idle(input string nm);
        int i;
        i = 0;
        while (tx_ready !== 1'b1 && i < 300) begin @(posedge clk); #1; i++; end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL %s tx_ready got %b exp 1", nm, tx_ready); end
    endtask

    task automatic send_rx_byte(input logic [7:0] b);
        logic lvl;
        int i;
        lvl = gpio_to_pulpino[8];
        @(negedge clk); p_data = b; p_bw = ~p_bw;
        i = 0;
        while (gpio_to_pulpino[8] === lvl && i < 40) begin @(posedge clk); #1; i++; end
        checks++;
        if (gpio_to_pulpino[8] === lvl) begin errors++; $display("FAIL rx_byte_ack %h got %b exp %b", b, gpio_to_pulpino[8], ~lvl); end
    endtask

    task automatic rx_word_write(input logic [31:0] exp, input string nm);
        int i;
        @(negedge clk); p_ww = ~p_ww;
        i = 0;
        while (rx_valid !== 1'b1 && i < 40) begin @(posedge clk); #1; i++; end
        checks++;
        if (rx_valid !== 1'b1 || rx_word !== exp) begin
            errors++; $display("FAIL %s rx_valid %b rx_word got %h exp %h", nm, rx_valid, rx_word, exp);
        end
    endtask

    task automatic rx_consume(input string nm);
        logic lvl;
        lvl = gpio_to_pulpino[10];
        @(negedge clk); rx_ready = 1;
        @(posedge clk); #1;
        checks++;
        if (gpio_to_pulpino[10] === lvl || rx_valid !== 1'b0) begin
            errors++; $display("FAIL %s word_ack bit10 got %b exp %b rx_valid %b", nm, gpio_to_pulpino[10], ~lvl, rx_valid);
        end
        @(negedge clk); rx_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; tx_valid = 0; tx_word = 0; rx_ready = 0; err_clr = 0; p_data = 0; p_bw = 0; p_ww = 0; ack_en = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({gpio_to_pulpino, rx_word, rx_valid, timeout_err, busy, tx_ready} !== 68'd0) begin
            errors++; $display("FAIL reset_outputs gpio %h rx_word %h flags %b%b%b%b exp all 0",
                               gpio_to_pulpino, rx_word, rx_valid, timeout_err, busy, tx_ready);
        end
        @(negedge clk); rst = 0; #1;
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_release tx_ready got %b exp 1", tx_ready); end
    endtask

    task automatic test_tx_basic();
        logic b9;
        logic [7:0] exp [4];
        exp[0] = 8'h00; exp[1] = 8'h03; exp[2] = 8'h00; exp[3] = 8'h07;
        tx_bytes.delete(); ww_flips = 0;
        b9 = gpio_to_pulpino[9];
        tx_send(32'h0003_0007);
        checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tx_accept tx_ready %b busy %b exp 0 1", tx_ready, busy); end
        @(posedge clk); #1;
        checks++;
        if (gpio_to_pulpino[9] === b9 || gpio_to_pulpino[7:0] !== 8'h00) begin
            errors++; $display("FAIL tx_first_byte bit9 %b data %h exp %b 00", gpio_to_pulpino[9], gpio_to_pulpino[7:0], ~b9);
        end
        tx_wait_idle("tx_basic_done");
        checks++;
        if (tx_bytes.size() != 4) begin errors++; $display("FAIL tx_byte_count got %0d exp 4", tx_bytes.size()); end
        for (int i = 0; i < 4 && i < tx_bytes.size(); i++) begin
            checks++;
            if (tx_bytes[i] !== exp[i]) begin errors++; $display("FAIL tx_byte%0d got %h exp %h", i, tx_bytes[i], exp[i]); end
        end
        checks++;
        if (ww_flips != 1 || ww_at != 4) begin errors++; $display("FAIL tx_word_toggle flips %0d after %0d bytes exp 1 after 4", ww_flips, ww_at); end
    endtask

    task automatic test_rx_basic();
        int b0, w0;
        b0 = br_flips; w0 = wr_flips;
        send_rx_byte(8'hDE); send_rx_byte(8'hAD); send_rx_byte(8'hBE); send_rx_byte(8'hEF);
        rx_word_write(32'hDEADBEEF, "rx_basic_word");
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (br_flips - b0 != 4 || wr_flips != w0 || rx_valid !== 1'b1) begin
            errors++; $display("FAIL rx_hold bit8 flips %0d bit10 flips %0d rx_valid %b exp 4 0 1", br_flips - b0, wr_flips - w0, rx_valid);
        end
        rx_consume("rx_basic_consume");
    endtask

    task automatic test_backpressure();
        int b0;
        send_rx_byte(8'h11); send_rx_byte(8'h22); send_rx_byte(8'h33); send_rx_byte(8'h44);
        rx_word_write(32'h11223344, "bp_first_word");
        b0 = br_flips;
        @(negedge clk); p_data = 8'h55; p_bw = ~p_bw;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (br_flips != b0) begin errors++; $display("FAIL bp_no_ack bit8 flips got %0d exp 0", br_flips - b0); end
        @(negedge clk); rx_ready = 1;
        @(posedge clk); #1;
        checks++;
        if (wr_flips == 0 || br_flips != b0 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release bit8 flips %0d rx_valid %b exp 0 0", br_flips - b0, rx_valid);
        end
        @(negedge clk); rx_ready = 0;
        @(posedge clk); #1;
        checks++;
        if (br_flips - b0 != 1) begin errors++; $display("FAIL bp_pending_ack bit8 flips got %0d exp 1", br_flips - b0); end
        send_rx_byte(8'h66); send_rx_byte(8'h77); send_rx_byte(8'h88);
        rx_word_write(32'h55667788, "bp_second_word");
        rx_consume("bp_consume");
    endtask

    task automatic test_short_word();
        int b0;
        send_rx_byte(8'hAB); send_rx_byte(8'hCD);
        b0 = br_flips;
        @(negedge clk); p_data = 8'h99; p_bw = ~p_bw; p_ww = ~p_ww;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b1 || rx_word !== 32'h00ABCD99 || br_flips - b0 != 1) begin
            errors++; $display("FAIL short_same_cycle rx_word got %h flips %0d exp 00abcd99 1", rx_word, br_flips - b0);
        end
        rx_consume("short_consume");
        rx_word_write(32'h0000_0000, "zero_byte_word");
        rx_consume("zero_consume");
    endtask

    task automatic test_timeout(input bit hold_clr);
        logic b9;
        ack_en = 0;
        err_clr = hold_clr;
        b9 = gpio_to_pulpino[9];
        tx_send(32'hA5A5_5A5A);
        @(posedge clk); #1;
        checks++;
        if (gpio_to_pulpino[9] === b9) begin errors++; $display("FAIL to_toggle bit9 got %b exp %b", gpio_to_pulpino[9], ~b9); end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early clr%0d timeout_err got %b exp 0", hold_clr, timeout_err); end
        @(posedge clk); #1;
        checks++;
        if (timeout_err !== 1'b1 || gpio_to_pulpino[9] === b9) begin
            errors++; $display("FAIL to_set clr%0d timeout_err %b bit9 %b exp 1 %b", hold_clr, timeout_err, gpio_to_pulpino[9], ~b9);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_ready !== 1'b1 || timeout_err !== !hold_clr) begin
            errors++; $display("FAIL to_after clr%0d tx_ready %b timeout_err %b exp 1 %b", hold_clr, tx_ready, timeout_err, !hold_clr);
        end
        @(negedge clk); err_clr = 1;
        @(posedge clk); #1;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear timeout_err got %b exp 0", timeout_err); end
        @(negedge clk); err_clr = 0;
        ack_en = 1;
    endtask

    task automatic test_duplex();
        logic [7:0] exp [4];
        exp[0] = 8'h12; exp[1] = 8'h34; exp[2] = 8'h56; exp[3] = 8'h78;
        tx_bytes.delete();
        fork
            begin tx_send(32'h1234_5678); tx_wait_idle("duplex_tx_done"); end
            begin
                send_rx_byte(8'hCA); send_rx_byte(8'hFE); send_rx_byte(8'hF0); send_rx_byte(8'h0D);
                rx_word_write(32'hCAFEF00D, "duplex_rx_word");
            end
        join
        checks++;
        if (tx_bytes.size() != 4) begin errors++; $display("FAIL duplex_tx_count got %0d exp 4", tx_bytes.size()); end
        for (int i = 0; i < 4 && i < tx_bytes.size(); i++) begin
            checks++;
            if (tx_bytes[i] !== exp[i]) begin errors++; $display("FAIL duplex_tx_byte%0d got %h exp %h", i, tx_bytes[i], exp[i]); end
        end
        rx_consume("duplex_consume");
    endtask

    task automatic test_reset_mid();
        int i;
        logic [7:0] exp [4];
        exp[0] = 8'h0B; exp[1] = 8'hAD; exp[2] = 8'hF0; exp[3] = 8'h0D;
        tx_bytes.delete();
        tx_send(32'hA1B2_C3D4);
        i = 0;
        while (tx_bytes.size() < 2 && i < 100) begin @(posedge clk); #1; i++; end
        checks++;
        if (tx_bytes.size() != 2) begin errors++; $display("FAIL rm_two_bytes got %0d exp 2", tx_bytes.size()); end
        @(negedge clk); rst = 1; p_data = 0; p_bw = 0; p_ww = 0;
        @(posedge clk); #1;
        checks++;
        if (gpio_to_pulpino !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL rm_pins gpio got %h busy %b exp 00000000 0", gpio_to_pulpino, busy);
        end
        @(negedge clk); rst = 0; #1;
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL rm_release tx_ready got %b exp 1", tx_ready); end
        tx_bytes.delete();
        tx_send(32'h0BAD_F00D);
        tx_wait_idle("rm_fresh_done");
        checks++;
        if (tx_bytes.size() != 4) begin errors++; $display("FAIL rm_fresh_count got %0d exp 4", tx_bytes.size()); end
        for (int k = 0; k < 4 && k < tx_bytes.size(); k++) begin
            checks++;
            if (tx_bytes[k] !== exp[k]) begin errors++; $display("FAIL rm_fresh_byte%0d got %h exp %h", k, tx_bytes[k], exp[k]); end
        end
    endtask

    initial begin
        checks = 0; errors = 0; ww_flips = 0; ww_at = 0; br_flips = 0; wr_flips = 0;
        test_reset();
        test_tx_basic();
        test_rx_basic();
        test_backpressure();
        test_short_word();
        test_timeout(1'b0);
        test_timeout(1'b1);
        do_reset();
        test_duplex();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end
endmodule
